// File: rtl/systolic_input_loader_if.sv
// Element-pair handshake and array-facing bus of the systolic input loader.
interface systolic_input_loader_if #(
    parameter int DATAWIDTH = 16,
    parameter int N_SIZE    = 3
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DATAWIDTH-1:0] a_elem;
    logic [DATAWIDTH-1:0] b_elem;
    logic                 array_valid_out;
    logic                 valid_out;
    logic [DATAWIDTH-1:0] matrix_a_out [N_SIZE];
    logic [DATAWIDTH-1:0] matrix_b_out [N_SIZE];
    logic                 busy;

    // master: the element source plus the array's result-valid feedback
    modport master (
        output in_valid, a_elem, b_elem, array_valid_out,
        input  in_ready, valid_out, matrix_a_out, matrix_b_out, busy
    );

    // slave: the loader itself
    modport slave (
        input  in_valid, a_elem, b_elem, array_valid_out,
        output in_ready, valid_out, matrix_a_out, matrix_b_out, busy
    );
endinterface

// File: rtl/systolic_input_loader.sv
// Ping-pong operand buffer feeding an NxN systolic array. Row-major element
// pairs fill one bank while the other bank is streamed as N contiguous beats
// (column k of A, row k of B on beat k). A new pair is launched only after
// the array's result burst has risen and fallen.

// One output lane: selects beat k of this lane's A row / B column.
module systolic_loader_lane #(
    parameter int DATAWIDTH = 16,
    parameter int N_SIZE    = 3,
    parameter int KW        = $clog2(N_SIZE)
) (
    input  logic                             stream,
    input  logic [KW-1:0]                    k,
    input  logic [N_SIZE-1:0][DATAWIDTH-1:0] a_row,  // A[rd_bank][lane][*]
    input  logic [N_SIZE-1:0][DATAWIDTH-1:0] b_col,  // B[rd_bank][*][lane]
    output logic [DATAWIDTH-1:0]             a_out,
    output logic [DATAWIDTH-1:0]             b_out
);
    // outputs are forced to zero whenever the loader is not streaming
    always_comb begin
        a_out = '0;
        b_out = '0;
        if (stream) begin
            a_out = a_row[k];
            b_out = b_col[k];
        end
    end
endmodule

module systolic_input_loader #(
    parameter int DATAWIDTH = 16,
    parameter int N_SIZE    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    systolic_input_loader_if.slave  bus
);
    localparam int CW = $clog2(N_SIZE * N_SIZE);
    localparam int KW = $clog2(N_SIZE);
    localparam logic [CW-1:0] LAST_CNT = CW'(N_SIZE * N_SIZE - 1);
    localparam logic [KW-1:0] LAST_K   = KW'(N_SIZE - 1);

    typedef enum logic [1:0] {IDLE, STREAM, WAIT_BUSY, WAIT_DONE} state_t;
    // one operand matrix, indexed [row][col]
    typedef logic [N_SIZE-1:0][N_SIZE-1:0][DATAWIDTH-1:0] mat_t;

    mat_t [1:0]      mem_a;
    mat_t [1:0]      mem_b;
    logic [CW-1:0]   wr_cnt;
    logic            wr_bank;
    logic            rd_bank;
    logic [1:0]      bank_full;
    logic [KW-1:0]   k;
    state_t          state, state_nxt;
    logic            stream;
    logic            accept;
    logic            fill;
    logic            rel;

    assign bus.in_ready = ~bank_full[wr_bank];
    assign accept       = bus.in_valid & ~bank_full[wr_bank];
    assign fill         = accept & (wr_cnt == LAST_CNT);
    assign rel          = (state == STREAM) & (k == LAST_K);

    // write side: decode wr_cnt into (row, col) of the bank being filled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
            mem_a   <= '0;
            mem_b   <= '0;
        end else if (accept) begin
            for (int r = 0; r < N_SIZE; r++) begin
                for (int c = 0; c < N_SIZE; c++) begin
                    if (wr_cnt == CW'(r * N_SIZE + c)) begin
                        mem_a[wr_bank][r][c] <= bus.a_elem;
                        mem_b[wr_bank][r][c] <= bus.b_elem;
                    end
                end
            end
            if (fill) begin
                wr_cnt  <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                wr_cnt  <= wr_cnt + 1'b1;
            end
        end
    end

    // bank occupancy: a fill and a release in one cycle always hit different banks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_full <= 2'b00;
        end else begin
            if (fill) bank_full[wr_bank] <= 1'b1;
            if (rel)  bank_full[rd_bank] <= 1'b0;
        end
    end

    // read side: beat counter and bank pointer for the stream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_bank <= 1'b0;
            k       <= '0;
        end else if (state == STREAM) begin
            k <= rel ? '0 : k + 1'b1;
            if (rel) rd_bank <= ~rd_bank;
        end else begin
            k <= '0;
        end
    end

    // stream FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next state; IDLE also sees the fill landing this cycle so the stream
    // starts right after the edge that accepts the last element
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (bank_full[rd_bank] || (fill && (wr_bank == rd_bank)))
                           state_nxt = STREAM;
            STREAM:    if (rel) state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (bus.array_valid_out) state_nxt = WAIT_DONE;
            WAIT_DONE: if (!bus.array_valid_out) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // FSM outputs; decoded straight from state so reset drops valid_out at once
    always_comb begin
        stream        = (state == STREAM);
        bus.valid_out = stream;
        bus.busy      = (state != IDLE);
    end

    for (genvar i = 0; i < N_SIZE; i++) begin : g_lane
        logic [N_SIZE-1:0][DATAWIDTH-1:0] a_row;
        logic [N_SIZE-1:0][DATAWIDTH-1:0] b_col;
        logic [DATAWIDTH-1:0]             a_out;
        logic [DATAWIDTH-1:0]             b_out;

        for (genvar j = 0; j < N_SIZE; j++) begin : g_tap
            assign a_row[j] = mem_a[rd_bank][i][j];
            assign b_col[j] = mem_b[rd_bank][j][i];
        end

        systolic_loader_lane #(
            .DATAWIDTH (DATAWIDTH),
            .N_SIZE    (N_SIZE),
            .KW        (KW)
        ) u_lane (
            .stream (stream),
            .k      (k),
            .a_row  (a_row),
            .b_col  (b_col),
            .a_out  (a_out),
            .b_out  (b_out)
        );

        assign bus.matrix_a_out[i] = a_out;
        assign bus.matrix_b_out[i] = b_out;
    end
endmodule

// File: tb/tb_systolic_input_loader.sv
// Bench for systolic_input_loader: directed table, multi-cycle corner cases
// and a randomized run, all checked against a queue-based reference model.
module tb_systolic_input_loader;
    localparam int DW = 16;
    localparam int N  = 3;
    localparam int NN = N * N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    systolic_input_loader_if #(.DATAWIDTH(DW), .N_SIZE(N)) bus ();

    systolic_input_loader #(.DATAWIDTH(DW), .N_SIZE(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [NN-1:0][DW-1:0] a;
        logic [NN-1:0][DW-1:0] b;
    } pair_t;

    typedef struct packed {
        logic                 in_valid;
        logic [DW-1:0]        a;
        logic [DW-1:0]        b;
        logic                 avo;
        logic                 rdy;
        logic                 vld;
        logic                 busy;
        logic [N-1:0][DW-1:0] ea;
        logic [N-1:0][DW-1:0] eb;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;
    int stalls = 0;

    // reference model: completed pairs waiting/streaming, partial pair, phase
    pair_t fq [$];
    pair_t part;
    int    part_cnt;
    int    ph;     // 0 idle, 1 streaming, 2 await burst start, 3 await burst end
    int    beat;

    vec_t tbl [16];

    function automatic vec_t mk(logic iv, int a, int b, logic avo, logic rdy, logic vld,
                                logic bsy, int a0, int a1, int a2, int b0, int b1, int b2);
        vec_t v;
        v.in_valid = iv;  v.a = DW'(a);  v.b = DW'(b);  v.avo = avo;
        v.rdy = rdy;  v.vld = vld;  v.busy = bsy;
        v.ea[0] = DW'(a0);  v.ea[1] = DW'(a1);  v.ea[2] = DW'(a2);
        v.eb[0] = DW'(b0);  v.eb[1] = DW'(b1);  v.eb[2] = DW'(b2);
        return v;
    endfunction

    function automatic pair_t rnd_pair();
        pair_t p;
        for (int i = 0; i < NN; i++) begin
            p.a[i] = DW'($urandom);
            p.b[i] = DW'($urandom);
        end
        return p;
    endfunction

    task automatic model_reset();
        fq.delete();
        part = '0;
        part_cnt = 0;
        ph = 0;
        beat = 0;
    endtask

    task automatic check_model();
        logic erdy, evld, ebsy;
        logic [DW-1:0] ea [N];
        logic [DW-1:0] eb [N];
        bit bad;
        int bl;
        erdy = (fq.size() < 2);
        evld = (ph == 1);
        ebsy = (ph != 0);
        bad = (bus.in_ready !== erdy) || (bus.valid_out !== evld) || (bus.busy !== ebsy);
        bl = 0;
        for (int i = 0; i < N; i++) begin
            ea[i] = '0;
            eb[i] = '0;
            if (evld) begin
                ea[i] = fq[0].a[i*N + beat];
                eb[i] = fq[0].b[beat*N + i];
            end
            if ((bus.matrix_a_out[i] !== ea[i]) || (bus.matrix_b_out[i] !== eb[i])) begin
                if (!bad) bl = i;
                bad = 1'b1;
            end
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL model @%0t rdy %b want %b vld %b want %b busy %b want %b lane%0d a %0d want %0d b %0d want %0d",
                     $time, bus.in_ready, erdy, bus.valid_out, evld, bus.busy, ebsy, bl,
                     bus.matrix_a_out[bl], ea[bl], bus.matrix_b_out[bl], eb[bl]);
        end
    endtask

    // advance the model by one clock edge using the inputs currently driven
    task automatic model_step();
        bit acc;
        int old_ph;
        acc = bus.in_valid && (fq.size() < 2);
        old_ph = ph;
        case (ph)
            1: if (beat == N-1) begin fq.delete(0); ph = 2; end
               else beat++;
            2: if (bus.array_valid_out) ph = 3;
            3: if (!bus.array_valid_out) ph = 0;
            default: ;
        endcase
        if (acc) begin
            part.a[part_cnt] = bus.a_elem;
            part.b[part_cnt] = bus.b_elem;
            part_cnt++;
            if (part_cnt == NN) begin
                fq.push_back(part);
                part_cnt = 0;
            end
        end
        if (old_ph == 0 && fq.size() > 0) begin
            ph = 1;
            beat = 0;
        end
    endtask

    task automatic cyc();
        #1;
        check_model();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t got %0h want %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_tbl(input int i);
        bit bad;
        bad = (bus.in_ready !== tbl[i].rdy) || (bus.valid_out !== tbl[i].vld) ||
              (bus.busy !== tbl[i].busy);
        for (int j = 0; j < N; j++)
            if ((bus.matrix_a_out[j] !== tbl[i].ea[j]) || (bus.matrix_b_out[j] !== tbl[i].eb[j]))
                bad = 1'b1;
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL table row %0d rdy %b want %b vld %b want %b busy %b want %b a={%0d,%0d,%0d} want {%0d,%0d,%0d} b={%0d,%0d,%0d} want {%0d,%0d,%0d}",
                     i, bus.in_ready, tbl[i].rdy, bus.valid_out, tbl[i].vld, bus.busy, tbl[i].busy,
                     bus.matrix_a_out[0], bus.matrix_a_out[1], bus.matrix_a_out[2],
                     tbl[i].ea[0], tbl[i].ea[1], tbl[i].ea[2],
                     bus.matrix_b_out[0], bus.matrix_b_out[1], bus.matrix_b_out[2],
                     tbl[i].eb[0], tbl[i].eb[1], tbl[i].eb[2]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        bus.in_valid = 1'b0;
        bus.array_valid_out = 1'b0;
        @(posedge clk);
        #1;
        check_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // present beats [from, to) of p, holding each until the model accepts it
    task automatic send_beats(input pair_t p, input int from, input int to, input bit gap);
        int idx;
        int guard;
        bit acc;
        idx = from;
        guard = 0;
        while (idx < to) begin
            bus.in_valid = 1'b1;
            bus.a_elem = p.a[idx];
            bus.b_elem = p.b[idx];
            acc = (fq.size() < 2);
            #1;
            if (!bus.in_ready) stalls++;
            cyc();
            if (acc) idx++;
            if (gap) begin
                bus.in_valid = 1'b0;
                cyc();
            end
            guard++;
            if (guard > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL send timeout @%0t beat %0d", $time, idx);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_for(input int tph, input int tbeat, input string what);
        int n;
        n = 0;
        while (!(ph == tph && (tbeat < 0 || beat == tbeat))) begin
            cyc();
            n++;
            if (n > 100) begin
                vectors++;
                miscompares++;
                $display("FAIL %s timeout @%0t", what, $time);
                return;
            end
        end
    endtask

    task automatic pulse_avo();
        bus.array_valid_out = 1'b1;
        cyc();
        cyc();
        bus.array_valid_out = 1'b0;
        cyc();
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog @%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        pair_t p1, p2, p3, p4;
        bus.in_valid = 1'b0;
        bus.a_elem = '0;
        bus.b_elem = '0;
        bus.array_valid_out = 1'b0;

        // A = 1..9 row-major, B = identity; stream starts right after beat 8
        for (int i = 0; i < NN; i++)
            tbl[i] = mk(1'b1, i + 1, (i % 4 == 0) ? 1 : 0, 1'b0, 1'b1, 1'b0, 1'b0, 0,0,0, 0,0,0);
        tbl[9]  = mk(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1,4,7, 1,0,0);
        tbl[10] = mk(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 2,5,8, 0,1,0);
        tbl[11] = mk(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 3,6,9, 0,0,1);
        tbl[12] = mk(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 0,0,0, 0,0,0);
        tbl[13] = mk(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 0,0,0, 0,0,0);
        tbl[14] = mk(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 0,0,0, 0,0,0);
        tbl[15] = mk(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0,0,0, 0,0,0);

        do_reset();
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = tbl[i].in_valid;
            bus.a_elem = tbl[i].a;
            bus.b_elem = tbl[i].b;
            bus.array_valid_out = tbl[i].avo;
            #1;
            check_tbl(i);
            cyc();
        end

        // ping-pong: two pairs back to back, second waits for the burst
        do_reset();
        stalls = 0;
        p1 = rnd_pair();
        p2 = rnd_pair();
        send_beats(p1, 0, NN, 1'b0);
        send_beats(p2, 0, NN, 1'b0);
        chk("pingpong_stalls", 32'(stalls), 32'd0);
        idle(4);
        pulse_avo();
        wait_for(2, -1, "pingpong_pair2");
        idle(2);

        // back-pressure: three pairs with the array burst never arriving
        do_reset();
        p1 = rnd_pair();  p2 = rnd_pair();  p3 = rnd_pair();  p4 = rnd_pair();
        send_beats(p1, 0, NN, 1'b0);
        send_beats(p2, 0, NN, 1'b0);
        send_beats(p3, 0, NN, 1'b0);
        idle(4);
        chk("backpressure_ready", 32'(bus.in_ready), 32'd0);
        pulse_avo();
        send_beats(p4, 0, NN, 1'b0);
        wait_for(2, -1, "backpressure_drain");
        pulse_avo();
        wait_for(2, -1, "backpressure_drain2");

        // gapped input
        do_reset();
        p1 = rnd_pair();
        send_beats(p1, 0, NN, 1'b1);
        wait_for(2, -1, "gapped_stream");

        // reset in the middle of a stream
        do_reset();
        p1 = rnd_pair();
        send_beats(p1, 0, NN, 1'b0);
        wait_for(1, 1, "reset_k1");
        rst = 1'b1;
        #1;
        chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_a_out", 32'({bus.matrix_a_out[0], bus.matrix_a_out[1]}), 32'd0);
        chk("rst_b_out", 32'({bus.matrix_b_out[0], bus.matrix_b_out[2]}), 32'd0);
        do_reset();
        chk("rst_banks", 32'({dut.wr_bank, dut.rd_bank, dut.bank_full}), 32'd0);
        p2 = rnd_pair();
        send_beats(p2, 0, NN, 1'b0);
        wait_for(2, -1, "rst_fresh_pair");

        // last beat of one pair lands on the release beat of another
        do_reset();
        p1 = rnd_pair();
        send_beats(p1, 0, NN, 1'b0);
        wait_for(2, -1, "sim_dummy");
        pulse_avo();
        p1 = rnd_pair();  p2 = rnd_pair();  p3 = rnd_pair();
        send_beats(p1, 0, NN, 1'b0);
        wait_for(2, -1, "sim_p0");
        send_beats(p2, 0, NN, 1'b0);
        send_beats(p3, 0, NN - 1, 1'b0);
        bus.array_valid_out = 1'b1;
        cyc();
        bus.array_valid_out = 1'b0;
        cyc();
        wait_for(1, 2, "sim_k2");
        send_beats(p3, NN - 1, NN, 1'b0);
        chk("sim_bank_full", 32'(dut.bank_full), 32'h2);
        chk("sim_rd_bank", 32'(dut.rd_bank), 32'h1);
        pulse_avo();
        wait_for(2, -1, "sim_p2_stream");

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.a_elem = DW'($urandom);
            bus.b_elem = DW'($urandom);
            if ($urandom_range(0, 3) == 0) bus.array_valid_out = ~bus.array_valid_out;
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
